// File: rtl/mem_bus_arbiter_pkg.sv
// Shared constants and types for the fetch / load-store memory bus arbiter.
package mem_bus_arbiter_pkg;

    localparam int          RegBusWidth = 32;
    localparam logic [31:0] ZeroWord    = 32'h0000_0000;
    localparam logic        RstEnable   = 1'b1;
    localparam logic        WriteEnable = 1'b1;
    localparam logic        ChipEnable  = 1'b1;
    localparam logic [3:0]  FetchSel    = 4'b1111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } arb_state_t;

    typedef enum logic {
        OWN_IF  = 1'b0,
        OWN_MEM = 1'b1
    } owner_t;

    typedef struct packed {
        logic [RegBusWidth-1:0] addr;
        logic [RegBusWidth-1:0] data;
        logic [3:0]             sel;
        logic                   we;
    } bus_cmd_t;

    // The fetch port is a full-word, read-only requester.
    function automatic bus_cmd_t fetch_cmd(input logic [RegBusWidth-1:0] addr);
        bus_cmd_t c;
        c.addr = addr;
        c.data = ZeroWord;
        c.sel  = FetchSel;
        c.we   = ~WriteEnable;
        return c;
    endfunction

endpackage

// File: rtl/mem_bus_arbiter_rr_grant2.sv
// Two-requester round-robin picker: on a tie the requester that did not own the bus last wins.
// Latency: combinational.
// Backpressure: none; the caller decides when the grant is consumed.
module rr_grant2
    import mem_bus_arbiter_pkg::*;
(
    input  logic req_if,
    input  logic req_mem,
    input  logic last_owner,
    output logic gnt_vld,
    output logic gnt_mem
);

    assign gnt_vld = req_if | req_mem;
    assign gnt_mem = req_mem & (~req_if | (last_owner == OWN_IF));

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one single-word memory bus between instruction fetch and the MEM-stage load/store port.
// Latency: request N -> strobe N+1; bus ack M -> port ack M+1; watchdog ends a hung cycle with err.
// Backpressure: requesters hold req until ack; stallreq stays high while a request is unanswered.
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int TIMEOUT = 255
)
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   if_req_i,
    input  logic                   mem_req_i,
    input  logic [RegBusWidth-1:0] if_addr_i,
    input  logic [RegBusWidth-1:0] mem_addr_i,
    input  logic                   mem_we_i,
    input  logic [3:0]             mem_sel_i,
    input  logic [RegBusWidth-1:0] mem_data_i,
    input  logic                   flush_i,
    output logic                   if_ack_o,
    output logic                   mem_ack_o,
    output logic [RegBusWidth-1:0] if_data_o,
    output logic [RegBusWidth-1:0] mem_data_o,
    output logic                   err_o,
    output logic                   stallreq_if_o,
    output logic                   stallreq_mem_o,
    output logic                   bus_stb_o,
    output logic                   bus_we_o,
    output logic [RegBusWidth-1:0] bus_addr_o,
    output logic [RegBusWidth-1:0] bus_data_o,
    output logic [3:0]             bus_sel_o,
    input  logic [RegBusWidth-1:0] bus_data_i,
    input  logic                   bus_ack_i
);

    arb_state_t             state_q;
    arb_state_t             state_d;
    owner_t                 owner_q;
    owner_t                 last_owner_q;
    logic [7:0]             wd_q;
    logic                   err_q;
    logic                   if_kill_q;
    logic [RegBusWidth-1:0] rdata_q;
    logic                   gnt_vld;
    logic                   gnt_mem;
    logic                   timeout_hit;
    bus_cmd_t               gnt_cmd;

    rr_grant2 u_rr_grant2 (
        .req_if     (if_req_i),
        .req_mem    (mem_req_i),
        .last_owner (last_owner_q),
        .gnt_vld    (gnt_vld),
        .gnt_mem    (gnt_mem)
    );

    assign timeout_hit = (wd_q == 8'(TIMEOUT));

    always_comb begin
        gnt_cmd = fetch_cmd(if_addr_i);
        if (gnt_mem) begin
            gnt_cmd.addr = mem_addr_i;
            gnt_cmd.data = mem_data_i;
            gnt_cmd.sel  = mem_sel_i;
            gnt_cmd.we   = mem_we_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (gnt_vld) state_d = ST_BUSY;
            ST_BUSY: if (bus_ack_i || timeout_hit) state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        if_ack_o  = 1'b0;
        mem_ack_o = 1'b0;
        if (state_q == ST_DONE) begin
            if_ack_o  = (owner_q == OWN_IF) && !if_kill_q;
            mem_ack_o = (owner_q == OWN_MEM);
        end
    end

    assign err_o          = err_q & (if_ack_o | mem_ack_o);
    assign stallreq_if_o  = if_req_i & ~if_ack_o;
    assign stallreq_mem_o = mem_req_i & ~mem_ack_o;
    assign if_data_o      = rdata_q;
    assign mem_data_o     = rdata_q;

    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            owner_q      <= OWN_IF;
            last_owner_q <= OWN_IF;
            wd_q         <= 8'd0;
            err_q        <= 1'b0;
            if_kill_q    <= 1'b0;
            rdata_q      <= ZeroWord;
            bus_stb_o    <= 1'b0;
            bus_we_o     <= 1'b0;
            bus_addr_o   <= ZeroWord;
            bus_data_o   <= ZeroWord;
            bus_sel_o    <= 4'b0000;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (gnt_vld) begin
                        owner_q    <= gnt_mem ? OWN_MEM : OWN_IF;
                        bus_addr_o <= gnt_cmd.addr;
                        bus_data_o <= gnt_cmd.data;
                        bus_sel_o  <= gnt_cmd.sel;
                        bus_we_o   <= gnt_cmd.we;
                        bus_stb_o  <= ChipEnable;
                        wd_q       <= 8'd0;
                        err_q      <= 1'b0;
                        // A flush in the grant cycle already invalidates this fetch.
                        if_kill_q  <= flush_i && !gnt_mem;
                    end
                end
                ST_BUSY: begin
                    if (flush_i && owner_q == OWN_IF) begin
                        if_kill_q <= 1'b1;
                    end
                    if (bus_ack_i) begin
                        rdata_q   <= (bus_we_o == WriteEnable) ? ZeroWord : bus_data_i;
                        bus_stb_o <= 1'b0;
                    end else if (timeout_hit) begin
                        rdata_q   <= ZeroWord;
                        err_q     <= 1'b1;
                        bus_stb_o <= 1'b0;
                    end else begin
                        wd_q <= wd_q + 8'd1;
                    end
                end
                ST_DONE: begin
                    last_owner_q <= owner_q;
                    if_kill_q    <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter with a transaction-level reference model checked every cycle.
module tb_mem_bus_arbiter;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        if_req_i = 1'b0, mem_req_i = 1'b0;
    logic [31:0] if_addr_i = '0, mem_addr_i = '0, mem_data_i = '0;
    logic        mem_we_i = 1'b0;
    logic [3:0]  mem_sel_i = 4'hF;
    logic        flush_i = 1'b0;
    logic        if_ack_o, mem_ack_o, err_o, stallreq_if_o, stallreq_mem_o;
    logic [31:0] if_data_o, mem_data_o;
    logic        bus_stb_o, bus_we_o;
    logic [31:0] bus_addr_o, bus_data_o;
    logic [3:0]  bus_sel_o;
    logic [31:0] bus_data_i = '0;
    logic        bus_ack_i = 1'b0;

    mem_bus_arbiter #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .if_req_i(if_req_i), .mem_req_i(mem_req_i),
        .if_addr_i(if_addr_i), .mem_addr_i(mem_addr_i),
        .mem_we_i(mem_we_i), .mem_sel_i(mem_sel_i), .mem_data_i(mem_data_i),
        .flush_i(flush_i),
        .if_ack_o(if_ack_o), .mem_ack_o(mem_ack_o),
        .if_data_o(if_data_o), .mem_data_o(mem_data_o),
        .err_o(err_o), .stallreq_if_o(stallreq_if_o), .stallreq_mem_o(stallreq_mem_o),
        .bus_stb_o(bus_stb_o), .bus_we_o(bus_we_o),
        .bus_addr_o(bus_addr_o), .bus_data_o(bus_data_o), .bus_sel_o(bus_sel_o),
        .bus_data_i(bus_data_i), .bus_ack_i(bus_ack_i)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    bit cmp_en = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Bus slave: acks after ack_delay strobe cycles (negative = never); force_ack drives ack with no strobe.
    int ack_delay = -1;
    bit force_ack = 0;
    int scnt = 0;
    always @(posedge clk) begin
        #1;
        if (bus_stb_o) begin
            bus_ack_i = (ack_delay >= 0) && (scnt == ack_delay);
            scnt++;
        end else begin
            scnt = 0;
            bus_ack_i = force_ack;
        end
    end

    // Reference model: one outstanding transaction, described by whether the strobe is out,
    // how many strobe cycles have elapsed, and a pending completion to report next cycle.
    bit          m_stb = 0, m_cmp = 0, m_cmp_err = 0, m_kill = 0, m_cmp_kill = 0;
    bit          m_own = 0, m_cmp_own = 0, m_last = 0;   // 1 = mem port
    int          m_age = 0;
    bit          m_we = 0;
    logic [3:0]  m_sel = '0;
    logic [31:0] m_addr = '0, m_wdat = '0, m_cmp_data = '0;

    task automatic finish(input logic [31:0] d, input bit e);
        m_stb      = 0;
        m_cmp      = 1;
        m_cmp_own  = m_own;
        m_cmp_err  = e;
        m_cmp_data = d;
        m_cmp_kill = m_kill;
        m_last     = m_own;
        m_kill     = 0;
    endtask

    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            m_stb = 0; m_cmp = 0; m_kill = 0; m_last = 0;
        end else if (m_cmp) begin
            m_cmp = 0;
        end else if (m_stb) begin
            if (flush_i && !m_own) m_kill = 1;
            if (bus_ack_i)        finish(m_we ? 32'h0 : bus_data_i, 0);
            else if (m_age == TO) finish(32'h0, 1);
            else                  m_age++;
        end else if (if_req_i || mem_req_i) begin
            if (if_req_i && mem_req_i) m_own = !m_last;
            else                       m_own = mem_req_i;
            m_addr = m_own ? mem_addr_i : if_addr_i;
            m_we   = m_own ? mem_we_i : 1'b0;
            m_sel  = m_own ? mem_sel_i : 4'hF;
            m_wdat = m_own ? mem_data_i : 32'h0;
            m_stb  = 1;
            m_age  = 0;
            m_kill = flush_i && !m_own;
        end
    end

    int          ack_log[$];
    int          if_ack_cyc = 0, stb_cnt = 0;
    logic [31:0] if_data_cap = '0, mem_data_cap = '0;
    logic        err_cap = 0;

    always @(negedge clk) begin
        bit e_if, e_mem;
        if (cmp_en) begin
            e_if  = m_cmp && !m_cmp_own && !m_cmp_kill;
            e_mem = m_cmp && m_cmp_own;
            chk("if_ack", if_ack_o, e_if);
            chk("mem_ack", mem_ack_o, e_mem);
            chk("err", err_o, m_cmp_err && (e_if || e_mem));
            chk("stallreq_if", stallreq_if_o, if_req_i && !e_if);
            chk("stallreq_mem", stallreq_mem_o, mem_req_i && !e_mem);
            chk("bus_stb", bus_stb_o, m_stb);
            if (m_stb) begin
                chk("bus_addr", bus_addr_o, m_addr);
                chk("bus_we", bus_we_o, m_we);
                chk("bus_sel", bus_sel_o, m_sel);
                chk("bus_data", bus_data_o, m_wdat);
            end
            if (e_if)  chk("if_data", if_data_o, m_cmp_data);
            if (e_mem) chk("mem_data", mem_data_o, m_cmp_data);
            if (bus_stb_o) stb_cnt++;
            if (if_ack_o === 1'b1) begin
                ack_log.push_back(0); if_ack_cyc = cyc; if_data_cap = if_data_o; err_cap = err_o;
            end
            if (mem_ack_o === 1'b1) begin
                ack_log.push_back(1); mem_data_cap = mem_data_o; err_cap = err_o;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin @(posedge clk); #2; end
    endtask

    task automatic wait_ack(input bit mem, input int limit, input bit drop);
        bit got = 0;
        for (int i = 0; i < limit && !got; i++) begin
            @(negedge clk);
            got = mem ? (mem_ack_o === 1'b1) : (if_ack_o === 1'b1);
        end
        if (!got) chk(mem ? "mem_ack_wait" : "if_ack_wait", 32'd0, 32'd1);
        @(posedge clk); #2;
        if (drop) begin
            if (mem) mem_req_i = 0; else if_req_i = 0;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: got running expected finished");
        errors++;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1);
    end

    initial begin
        int t0;
        tick(2);
        cmp_en = 1;
        chk("rst_stb", bus_stb_o, 0);
        chk("rst_sel", bus_sel_o, 4'b0000);
        chk("rst_addr", bus_addr_o, 32'h0);
        chk("rst_if_data", if_data_o, 32'h0);
        chk("rst_mem_data", mem_data_o, 32'h0);
        rst = 0;
        tick(1);

        // Fetch only, ack in the first strobe cycle.
        bus_data_i = 32'hDEADBEEF; ack_delay = 0; if_addr_i = 32'h100;
        if_req_i = 1; t0 = cyc;
        wait_ack(0, 20, 1);
        chk("t1_latency", if_ack_cyc - t0, 2);
        chk("t1_data", if_data_cap, 32'hDEADBEEF);
        tick(1);

        // Tie from reset: mem first, then an immediate mem re-request ties again and fetch wins.
        rst = 1; tick(1); rst = 0;
        ack_log.delete();
        bus_data_i = 32'h11112222; ack_delay = 1;
        if_addr_i = 32'h140; mem_addr_i = 32'h200; mem_we_i = 0; mem_sel_i = 4'hF;
        if_req_i = 1; mem_req_i = 1;
        wait_ack(1, 20, 0);
        mem_addr_i = 32'h208;
        wait_ack(0, 20, 1);
        wait_ack(1, 20, 1);
        chk("t2_count", ack_log.size(), 3);
        if (ack_log.size() == 3) begin
            chk("t2_first", ack_log[0], 1);
            chk("t2_second", ack_log[1], 0);
            chk("t2_third", ack_log[2], 1);
        end
        tick(1);

        // Mem write: bus carries the store exactly, read data returns 0.
        bus_data_i = 32'h55555555; ack_delay = 0;
        mem_we_i = 1; mem_sel_i = 4'b0011; mem_data_i = 32'hAABBCCDD; mem_addr_i = 32'h204;
        mem_req_i = 1;
        tick(1);
        chk("t3_addr", bus_addr_o, 32'h204);
        chk("t3_sel", bus_sel_o, 4'b0011);
        chk("t3_wdata", bus_data_o, 32'hAABBCCDD);
        chk("t3_we", bus_we_o, 1);
        wait_ack(1, 20, 1);
        chk("t3_rdata", mem_data_cap, 32'h0);
        mem_we_i = 0; mem_sel_i = 4'hF;
        tick(1);

        // Watchdog expiry, then a bus ack landing on the expiry cycle.
        ack_delay = -1; mem_addr_i = 32'h300; stb_cnt = 0;
        mem_req_i = 1;
        wait_ack(1, 30, 1);
        chk("t4_stb_cycles", stb_cnt, TO + 1);
        chk("t4_err", err_cap, 1);
        chk("t4_data", mem_data_cap, 32'h0);
        tick(1);
        ack_delay = TO; bus_data_i = 32'h0BADF00D; stb_cnt = 0;
        mem_req_i = 1;
        wait_ack(1, 30, 1);
        chk("t4b_stb_cycles", stb_cnt, TO + 1);
        chk("t4b_err", err_cap, 0);
        chk("t4b_data", mem_data_cap, 32'h0BADF00D);
        tick(1);

        // Flush during a fetch: no fetch ack, queued mem request follows.
        ack_delay = 3; if_addr_i = 32'h180; ack_log.delete();
        if_req_i = 1;
        tick(2);
        flush_i = 1; mem_req_i = 1; mem_addr_i = 32'h310;
        tick(1);
        flush_i = 0; if_req_i = 0;
        wait_ack(1, 30, 1);
        chk("t5_acks", ack_log.size(), 1);
        if (ack_log.size() == 1) chk("t5_owner", ack_log[0], 1);
        tick(1);

        // Reset mid-transaction, then a stray bus ack with nothing outstanding.
        ack_delay = -1; if_addr_i = 32'h1C0;
        if_req_i = 1;
        tick(2);
        rst = 1;
        tick(1);
        chk("t6_stb", bus_stb_o, 0);
        chk("t6_sel", bus_sel_o, 4'b0000);
        rst = 0; if_req_i = 0; ack_log.delete();
        force_ack = 1;
        tick(3);
        force_ack = 0;
        chk("t6_no_ack", ack_log.size(), 0);
        tick(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
